// File: rtl/cpu_run_monitor_pkg.sv
// Shared types and defaults for the run-control / register-dump monitor.
// Imported by the monitor top and reusable by the core that it watches.
package cpu_run_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } run_state_e;

  localparam int DEF_WIDTH       = 12;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_NUM_REGS    = 8;
  localparam int DEF_MAX_CYCLES  = 40;
  localparam int DEF_HALT_STABLE = 4;
  localparam int CNT_W           = 16;

  // The stall counter must be able to hold HALT_STABLE-1.
  function automatic int stable_width(input int halt_stable);
    return $clog2(halt_stable) + 1;
  endfunction

endpackage

// File: rtl/cpu_run_monitor_if.sv
// Snoop port (register write-back + PC) and register-dump stream of the run monitor.
// master = core/consumer side, slave = monitor side.
interface cpu_run_monitor_if #(
  parameter int WIDTH      = 12,
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 3
) ();

  logic                  wb_we;
  logic [IDX_W-1:0]      wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [WIDTH-1:0]      pc;

  logic                  dump_valid;
  logic                  dump_ready;
  logic [IDX_W-1:0]      dump_idx;
  logic [DATA_WIDTH-1:0] dump_data;
  logic                  dump_last;

  modport master (
    output wb_we, wb_addr, wb_data, pc, dump_ready,
    input  dump_valid, dump_idx, dump_data, dump_last
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, pc, dump_ready,
    output dump_valid, dump_idx, dump_data, dump_last
  );

endinterface

// File: rtl/cpu_run_monitor_shadow_regfile.sv
// Shadow register file: one write port, one asynchronous read port,
// every entry cleared by synchronous reset.
module shadow_regfile #(
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [$clog2(NUM_REGS)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]       rdata
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] rd_mux [NUM_REGS];

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_WIDTH-1:0] reg_q;
      logic [DATA_WIDTH-1:0] reg_d;

      always_comb begin
        reg_d = reg_q;
        if (we && (waddr == IDX_W'(gi))) begin
          reg_d = wdata;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign rd_mux[gi] = reg_q;
    end
  endgenerate

  assign rdata = rd_mux[raddr];

endmodule

// File: rtl/cpu_run_monitor.sv
// Run-control harness: shadows the core register file, ends the run on a cycle
// budget or a stalled PC, then streams every shadow register over valid/ready.
module cpu_run_monitor
  import cpu_run_monitor_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
  parameter int HALT_STABLE = DEF_HALT_STABLE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  cpu_run_monitor_if.slave   bus,
  output logic               running,
  output logic               timeout,
  output logic               halted,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               done
);

  localparam int               IDX_W      = $clog2(NUM_REGS);
  localparam int               ST_W       = stable_width(HALT_STABLE);
  localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_CYCLES);
  localparam logic [ST_W-1:0]  STABLE_LIM = ST_W'(HALT_STABLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REGS - 1);

  run_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cycle_q, cycle_d;
  logic [ST_W-1:0]       stable_q, stable_d;
  logic [WIDTH-1:0]      pc_prev_q, pc_prev_d;
  logic                  timeout_q, timeout_d;
  logic                  halted_q, halted_d;
  logic                  dump_valid_q, dump_valid_d;
  logic [IDX_W-1:0]      dump_idx_q, dump_idx_d;
  logic [DATA_WIDTH-1:0] dump_data_q, dump_data_d;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  shadow_we;

  shadow_regfile #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shadow (
    .clk   (clk),
    .reset (reset),
    .we    (shadow_we),
    .waddr (bus.wb_addr),
    .wdata (bus.wb_data),
    .raddr (dump_idx_d),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cycle_q      <= '0;
      stable_q     <= '0;
      pc_prev_q    <= '0;
      timeout_q    <= 1'b0;
      halted_q     <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_idx_q   <= '0;
      dump_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cycle_q      <= cycle_d;
      stable_q     <= stable_d;
      pc_prev_q    <= pc_prev_d;
      timeout_q    <= timeout_d;
      halted_q     <= halted_d;
      dump_valid_q <= dump_valid_d;
      dump_idx_q   <= dump_idx_d;
      dump_data_q  <= dump_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cycle_d      = cycle_q;
    stable_d     = stable_q;
    pc_prev_d    = bus.pc;
    timeout_d    = timeout_q;
    halted_d     = halted_q;
    dump_valid_d = dump_valid_q;
    dump_idx_d   = dump_idx_q;
    shadow_we    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RUN;
          cycle_d   = '0;
          stable_d  = '0;
          timeout_d = 1'b0;
          halted_d  = 1'b0;
        end
      end
      ST_RUN: begin
        shadow_we = bus.wb_we;
        if (cycle_q != MAX_CNT) begin
          cycle_d = cycle_q + 1'b1;
        end
        stable_d  = (bus.pc == pc_prev_q) ? stable_q + 1'b1 : '0;
        timeout_d = (cycle_d == MAX_CNT);
        halted_d  = (stable_d == STABLE_LIM);
        if (timeout_d || halted_d) begin
          state_d      = ST_DUMP;
          dump_valid_d = 1'b1;
        end
      end
      ST_DUMP: begin
        if (dump_valid_q && bus.dump_ready) begin
          if (dump_idx_q == LAST_IDX) begin
            state_d      = ST_DONE;
            dump_valid_d = 1'b0;
            dump_idx_d   = '0;
          end else begin
            dump_idx_d = dump_idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A write landing in the exit cycle must reach the first beat, so bypass the file.
    dump_data_d = (shadow_we && (bus.wb_addr == dump_idx_d)) ? bus.wb_data : rd_data;
  end

  assign running        = (state_q == ST_RUN);
  assign done           = (state_q == ST_DONE);
  assign timeout        = timeout_q;
  assign halted         = halted_q;
  assign cycle_count    = cycle_q;
  assign bus.dump_valid = dump_valid_q;
  assign bus.dump_idx   = dump_idx_q;
  assign bus.dump_data  = dump_data_q;
  assign bus.dump_last  = dump_valid_q && (dump_idx_q == LAST_IDX);

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: two instances (8x16 and 16x32) driven in lockstep,
// directed scenario table plus randomized runs checked against a run-level model.
module tb_cpu_run_monitor;

  localparam int MAXC = 40;
  localparam int HS   = 4;
  localparam int NA   = 8;
  localparam int NB   = 16;

  logic        clk = 1'b0;
  logic        reset, start, wb_we, dump_ready;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [11:0] pc;

  logic        running_a, timeout_a, halted_a, done_a;
  logic        running_b, timeout_b, halted_b, done_b;
  logic [15:0] cc_a, cc_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpu_run_monitor_if #(.WIDTH(12), .DATA_WIDTH(16), .IDX_W(3)) ifa ();
  cpu_run_monitor_if #(.WIDTH(12), .DATA_WIDTH(32), .IDX_W(4)) ifb ();

  assign ifa.wb_we = wb_we;  assign ifa.wb_addr = wb_addr[2:0]; assign ifa.wb_data = wb_data[15:0];
  assign ifa.pc = pc;        assign ifa.dump_ready = dump_ready;
  assign ifb.wb_we = wb_we;  assign ifb.wb_addr = wb_addr;      assign ifb.wb_data = wb_data;
  assign ifb.pc = pc;        assign ifb.dump_ready = dump_ready;

  cpu_run_monitor #(.WIDTH(12), .DATA_WIDTH(16), .NUM_REGS(NA), .MAX_CYCLES(MAXC), .HALT_STABLE(HS)) dut_a (
    .clk(clk), .reset(reset), .start(start), .bus(ifa), .running(running_a),
    .timeout(timeout_a), .halted(halted_a), .cycle_count(cc_a), .done(done_a));

  cpu_run_monitor #(.WIDTH(12), .DATA_WIDTH(32), .NUM_REGS(NB), .MAX_CYCLES(MAXC), .HALT_STABLE(HS)) dut_b (
    .clk(clk), .reset(reset), .start(start), .bus(ifb), .running(running_b),
    .timeout(timeout_b), .halted(halted_b), .cycle_count(cc_b), .done(done_b));

  // Run stimulus: pc_seq[0] is the pc in the start cycle, pc_seq[k+1] the pc in RUN cycle k.
  logic [11:0] pc_seq   [0:MAXC];
  logic        we_seq   [0:MAXC-1];
  logic [3:0]  addr_seq [0:MAXC-1];
  logic [31:0] data_seq [0:MAXC-1];
  logic [31:0] sh_a [NA];
  logic [31:0] sh_b [NB];

  typedef struct {
    int hold_at;     // pc ramps then holds from this RUN cycle; -1 held from start, -2 random 0/1
    bit alt_msb;     // pc alternates 0x000/0x800
    int wr_set;      // 0 none, 1 r1/r2/r3 + r7=BEEF at cycle 39, 2 r0 every cycle, 3 random
    int ready_mode;  // 0 pattern 1,0,0,1  1 random  2 always 1
    int exp_cc;
    bit exp_to;
    bit exp_h;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) sh_a[i] = '0;
    for (int i = 0; i < NB; i++) sh_b[i] = '0;
  endtask

  task automatic gen_pc(input int hold_at, input bit alt_msb, input logic [11:0] base);
    for (int i = 0; i <= MAXC; i++) begin
      if (alt_msb)          pc_seq[i] = (i % 2 == 1) ? 12'h800 : 12'h000;
      else if (hold_at == -2) pc_seq[i] = 12'($urandom_range(0, 1));
      else if (hold_at < 0) pc_seq[i] = base;
      else if (i == 0)      pc_seq[i] = base - 12'd1;
      else                  pc_seq[i] = base + 12'(((i - 1) < hold_at) ? (i - 1) : hold_at);
    end
  endtask

  task automatic gen_wr(input int wr_set);
    for (int k = 0; k < MAXC; k++) begin
      we_seq[k] = 1'b0; addr_seq[k] = '0; data_seq[k] = '0;
      case (wr_set)
        1: begin
          if (k == 2)  begin we_seq[k] = 1'b1; addr_seq[k] = 4'd1; data_seq[k] = 32'd5;      end
          if (k == 3)  begin we_seq[k] = 1'b1; addr_seq[k] = 4'd2; data_seq[k] = 32'd7;      end
          if (k == 4)  begin we_seq[k] = 1'b1; addr_seq[k] = 4'd3; data_seq[k] = 32'd12;     end
          if (k == 39) begin we_seq[k] = 1'b1; addr_seq[k] = 4'd7; data_seq[k] = 32'hBEEF;   end
        end
        2: begin we_seq[k] = 1'b1; addr_seq[k] = 4'd0; data_seq[k] = 32'hA5A5_0000 + 32'(k); end
        3: begin
          we_seq[k] = 1'($urandom_range(0, 1)); addr_seq[k] = 4'($urandom); data_seq[k] = $urandom;
        end
        default: ;
      endcase
    end
  endtask

  // Run-level model: the run ends at the first RUN cycle closing HS-1 consecutive
  // equal-pc comparisons, or at the last budgeted cycle; writes up to and including it land.
  task automatic model_run(output int exit_k, output bit to_o, output bit halt_o);
    int eq;
    exit_k = MAXC - 1;
    halt_o = 1'b0;
    for (int k = 0; k < MAXC; k++) begin
      eq = 0;
      for (int j = k; j >= 0; j--) begin
        if (pc_seq[j + 1] == pc_seq[j]) eq++;
        else break;
      end
      if (eq >= HS - 1) begin
        exit_k = k; halt_o = 1'b1;
        break;
      end
    end
    to_o = (exit_k == MAXC - 1);
    for (int k = 0; k <= exit_k; k++) begin
      if (we_seq[k]) begin
        sh_b[addr_seq[k]]      = data_seq[k];
        sh_a[addr_seq[k][2:0]] = {16'h0, data_seq[k][15:0]};
      end
    end
  endtask

  task automatic do_run(input int ready_mode, input bit pulse_start, input int abort_at, output int exit_k);
    bit exp_to, exp_h;
    int ca, cb, cyc;
    model_run(exit_k, exp_to, exp_h);
    $display("[TB] run: exit_cycle=%0d timeout=%0b halted=%0b", exit_k, exp_to, exp_h);
    start = 1'b1; pc = pc_seq[0]; dump_ready = 1'b0;
    wb_we = 1'b1; wb_addr = 4'($urandom); wb_data = $urandom;
    step();
    start = 1'b0;
    check("run_entry", {running_a, running_b, cc_a, cc_b}, {2'b11, 32'h0});
    for (int k = 0; k <= exit_k; k++) begin
      pc = pc_seq[k + 1]; wb_we = we_seq[k]; wb_addr = addr_seq[k]; wb_data = data_seq[k];
      step();
      check("cc_a", cc_a, k + 1);
      check("cc_b", cc_b, k + 1);
      if (k < exit_k) check("running", {running_a, running_b}, 2'b11);
      else check("exit", {running_a, running_b, ifa.dump_valid, ifb.dump_valid}, 4'b0011);
    end
    ca = 0; cb = 0; cyc = 0;
    while (!(ca == NA && cb == NB) && cyc < 200) begin
      if (abort_at >= 0 && ca == abort_at) begin
        reset = 1'b1; dump_ready = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        check("abort_flags", {running_a, done_a, timeout_a, halted_a, ifa.dump_valid,
                              running_b, done_b, timeout_b, halted_b, ifb.dump_valid}, 0);
        check("abort_cnt", {cc_a, cc_b}, 0);
        check("abort_idx", {ifa.dump_idx, ifb.dump_idx}, 0);
        return;
      end
      case (ready_mode)
        0:       dump_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        1:       dump_ready = 1'($urandom_range(0, 1));
        default: dump_ready = 1'b1;
      endcase
      start = pulse_start && (cyc == 1);
      wb_we = 1'b1; wb_addr = 4'($urandom); wb_data = $urandom; pc = 12'($urandom);
      check("a_valid", ifa.dump_valid, ca < NA);
      if (ifa.dump_valid && ca < NA) begin
        check("a_idx", ifa.dump_idx, ca);
        check("a_data", ifa.dump_data, sh_a[ca]);
        check("a_last", ifa.dump_last, ca == NA - 1);
        if (dump_ready) ca++;
      end
      check("b_valid", ifb.dump_valid, cb < NB);
      if (ifb.dump_valid && cb < NB) begin
        check("b_idx", ifb.dump_idx, cb);
        check("b_data", ifb.dump_data, sh_b[cb]);
        check("b_last", ifb.dump_last, cb == NB - 1);
        if (dump_ready) cb++;
      end
      step();
      cyc++;
    end
    start = 1'b0; dump_ready = 1'b0; wb_we = 1'b0;
    check("dump_in_budget", cyc < 200, 1);
    check("end_state", {done_a, done_b, running_a, running_b, ifa.dump_valid, ifb.dump_valid}, 6'b110000);
    check("end_idx", {ifa.dump_idx, ifb.dump_idx}, 0);
    check("end_flags", {timeout_a, halted_a, timeout_b, halted_b}, {exp_to, exp_h, exp_to, exp_h});
    check("end_cc", {cc_a, cc_b}, {16'(exit_k + 1), 16'(exit_k + 1)});
  endtask

  initial begin
    int ek;
    reset = 1'b1; start = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0; pc = '0; dump_ready = 1'b0;

    tbl[0] = '{100, 1'b0, 1, 0, 40, 1'b1, 1'b0};
    tbl[1] = '{9,   1'b0, 0, 1, 13, 1'b0, 1'b1};
    tbl[2] = '{-1,  1'b0, 2, 2, 3,  1'b0, 1'b1};
    tbl[3] = '{36,  1'b0, 0, 1, 40, 1'b1, 1'b1};
    tbl[4] = '{37,  1'b0, 0, 0, 40, 1'b1, 1'b0};
    tbl[5] = '{0,   1'b1, 0, 1, 40, 1'b1, 1'b0};

    // Reset held while the core writes and start is pulsed: nothing may stick.
    start = 1'b1; wb_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wb_addr = 4'(i + 1); wb_data = 32'hFFFF_0000 + 32'(i); pc = 12'(i);
      step();
    end
    reset = 1'b0; start = 1'b0; wb_we = 1'b0;
    check("rst_flags", {running_a, timeout_a, halted_a, done_a, ifa.dump_valid, ifa.dump_last,
                        running_b, timeout_b, halted_b, done_b, ifb.dump_valid, ifb.dump_last}, 0);
    check("rst_cnt", {cc_a, cc_b}, 0);
    step();
    check("idle_hold", {running_a, done_a, ifa.dump_valid, running_b, done_b, ifb.dump_valid}, 0);
    model_reset();

    for (int i = 0; i < 6; i++) begin
      gen_pc(tbl[i].hold_at, tbl[i].alt_msb, 12'($urandom));
      gen_wr(tbl[i].wr_set);
      do_run(tbl[i].ready_mode, i == 0, -1, ek);
      check("tbl_cc", {cc_a, cc_b}, {16'(tbl[i].exp_cc), 16'(tbl[i].exp_cc)});
      check("tbl_to", {timeout_a, timeout_b}, {2{tbl[i].exp_to}});
      check("tbl_halt", {halted_a, halted_b}, {2{tbl[i].exp_h}});
    end

    for (int r = 0; r < 8; r++) begin
      gen_pc((r % 2 == 0) ? -2 : int'($urandom_range(0, 45)) - 1, 1'b0, 12'($urandom));
      gen_wr(3);
      do_run(1, r % 3 == 0, -1, ek);
    end

    // Reset during beat 3, then a write-free run must dump all zeros.
    gen_pc(-2, 1'b0, 12'h0);
    gen_wr(3);
    do_run(2, 1'b0, 3, ek);
    dump_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("post_abort", {ifa.dump_valid, ifb.dump_valid, running_a, running_b}, 0);
    end
    gen_pc(5, 1'b0, 12'($urandom));
    gen_wr(0);
    do_run(2, 1'b0, -1, ek);
    check("zero_run_cc", cc_a, 16'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
